// File: rtl/spi_slave_sys_pkg.sv
// Shared SPI definitions: FSM state encoding and default byte width.
// Used by spi_slave_sys and the spi_m benches.
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    typedef enum logic [1:0] {
        ARM   = 2'd0,  // after reset: wait for cs to be seen high before accepting frames
        IDLE  = 2'd1,  // cs high, waiting for the next frame
        SHIFT = 2'd2   // cs low, shifting bytes
    } spi_state_e;

endpackage

// File: rtl/spi_slave_sys_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall detection.
//   clk, rst  system clock, async active-high reset (all flops load RST_VAL)
//   din       asynchronous input pin
//   dout      synchronized level
//   rise/fall one-clk pulses comparing dout with its previous value
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= dout;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_slave_sys.sv
// spi_slave_sys: system-clocked SPI slave, cs active low, LSB first.
// Master drives on sclk rise, this slave samples sdi on sclk fall; sclk, cs
// and sdi are oversampled in the clk domain (sclk period >= 8 clk).
// Ports:
//   clk, rst            system clock, async active-high reset
//   sclk, cs, sdi, sdo  SPI pins
//   tx_data/tx_load     one-byte tx buffer write (accepted when tx_ready=1)
//   tx_ready            tx buffer empty
//   rx_data/rx_valid    last received byte, one-clk pulse on update
//   frame_err           one-clk pulse when cs rises mid-byte
// Build option SPI_SLAVE_DAISY_EN: sdo becomes a DATA_W-bit delayed copy of
//   sdi (daisy-chain node), tx buffer removed, tx_ready tied 0.
module spi_slave_sys
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              sdi,
    output logic              sdo,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int ARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [ARM_W-1:0] ARM_MAX  = ARM_W'(SYNC_STAGES);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic sdi_s;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
        .clk(clk), .rst(rst), .din(sclk), .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .din(cs), .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sdi_sync <= '0;
        else     sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
    end
    assign sdi_s = sdi_sync[SYNC_STAGES-1];

    spi_state_e state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_shift, rx_next;
    logic [ARM_W-1:0]  arm_cnt;
    logic              frame_start, byte_done;
    logic              sdo_start, sdo_rise;

    assign frame_start = (state_q == IDLE) && cs_fall;
    // cs rise has priority over any sclk edge in the same clk
    assign byte_done   = (state_q == SHIFT) && !cs_rise && sclk_fall && (bit_cnt == LAST_BIT);
    assign rx_next     = {sdi_s, rx_shift[DATA_W-1:1]};

`ifdef SPI_SLAVE_DAISY_EN
    // rx_shift doubles as the delay line: bit 0 is the one leaving on the next fall
    wire unused_tx = ^{tx_data, tx_load, sclk_s};
    assign tx_ready  = 1'b0;
    assign sdo_start = 1'b0;
    assign sdo_rise  = rx_shift[0];
`else
    wire unused_tx = sclk_s;
    logic [DATA_W-1:0] tx_buf, tx_shift, tx_next_byte;
    logic              tx_full;

    assign tx_ready     = ~tx_full;
    assign tx_next_byte = tx_full ? tx_buf : '0;
    assign sdo_start    = tx_next_byte[0];
    assign sdo_rise     = tx_shift[bit_cnt];

    // A load in the same clk as an empty-buffer consume keeps the new byte:
    // the consumed byte goes out as 00 and the loaded one waits for the next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_buf   <= '0;
            tx_full  <= 1'b0;
            tx_shift <= '0;
        end else begin
            if (frame_start || byte_done) tx_shift <= tx_next_byte;
            if (tx_load && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end else if (frame_start || byte_done) begin
                tx_full <= 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ARM;
        else     state_q <= state_d;
    end

    // ARM waits until cs has read high for SYNC_STAGES+1 clks, so the reset
    // value still draining out of the synchronizer cannot make a frame in
    // progress look like an idle bus.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARM:     if (cs_s && arm_cnt == ARM_MAX) state_d = IDLE;
            IDLE:    if (cs_fall) state_d = SHIFT;
            SHIFT:   if (cs_rise) state_d = IDLE;
            default: state_d = ARM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdo       <= 1'b0;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            arm_cnt   <= '0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            unique case (state_q)
                ARM: begin
                    if (!cs_s)                arm_cnt <= '0;
                    else if (arm_cnt != ARM_MAX) arm_cnt <= arm_cnt + 1'b1;
                end
                IDLE: begin
                    if (cs_fall) begin
                        sdo      <= sdo_start;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        frame_err <= (bit_cnt != '0);
                        sdo       <= 1'b0;
                        bit_cnt   <= '0;
                    end else if (sclk_fall) begin
                        rx_shift <= rx_next;
                        if (byte_done) begin
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                            bit_cnt  <= '0;
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                    end else if (sclk_rise) begin
                        sdo <= sdo_rise;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_sys.sv
// Directed bench for spi_slave_sys: a behavioural SPI master (sclk = clk/8,
// drive on rise, sample on fall, LSB first), a table of single-byte frames,
// and hand-written sequences for reset, multi-byte, abort and load-at-start.
module tb_spi_slave_sys;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0, cs = 1'b0, sdi = 1'b0;
    logic       sdo;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err;

    spi_slave_sys #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .sdi(sdi), .sdo(sdo),
        .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int rv_cnt = 0;
    int fe_cnt = 0;
    logic [7:0] rx_hist[$];
    logic [7:0] mosi_q[2];
    logic [7:0] miso_q[2];

    always @(negedge clk) begin
        if (rx_valid) begin
            rv_cnt = rv_cnt + 1;
            rx_hist.push_back(rx_data);
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
    end

    initial begin
        #500us;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] b);
        @(negedge clk);
        tx_data = b;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    // Full frame of n bytes from mosi_q, sdo bytes into miso_q. With lf set,
    // tx_load is pulsed on the clk the slave acts on the synced cs fall.
    logic txr_after_load;
    task automatic run_frame(input int n, input bit lf, input logic [7:0] lfb);
        @(negedge clk);
        cs = 1'b0;
        if (lf) begin
            repeat (2) @(negedge clk);
            tx_data = lfb;
            tx_load = 1'b1;
            @(negedge clk);
            tx_load = 1'b0;
            @(negedge clk);
            txr_after_load = tx_ready;
        end else begin
            repeat (4) @(negedge clk);
        end
        for (int b = 0; b < n; b++) begin
            for (int i = 0; i < 8; i++) begin
                sdi  = mosi_q[b][i];
                sclk = 1'b1;
                repeat (4) @(negedge clk);
                miso_q[b][i] = sdo;
                sclk = 1'b0;
                repeat (4) @(negedge clk);
            end
        end
        cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        bit         ld;
        logic [7:0] ld_b;
        bit         ld2;
        logic [7:0] ld2_b;
        logic [7:0] mosi;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs[4];
    int   rv0, fe0, h0;
    logic [7:0] last_rx;
    logic sdo_before;

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 8'h3C, 8'h3C, 8'hA5};
        vecs[1] = '{1'b1, 8'hA5, 1'b1, 8'h5A, 8'hC3, 8'hC3, 8'hA5};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'hFF, 8'hFF, 8'h00};
        vecs[3] = '{1'b1, 8'h01, 1'b0, 8'h00, 8'h80, 8'h80, 8'h01};

        // Reset with cs low and sclk toggling: outputs at reset values, and
        // the frame already in progress must not be joined after release.
        rst = 1'b1;
        cs  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            sclk = ~sclk;
            sdi  = k[1];
            repeat (4) @(negedge clk);
            if (k == 2) begin
                chk("reset_sdo", sdo, 0);
`ifdef SPI_SLAVE_DAISY_EN
                chk("reset_tx_ready", tx_ready, 0);
`else
                chk("reset_tx_ready", tx_ready, 1);
`endif
                chk("reset_rx_data", rx_data, 0);
                chk("reset_rx_valid", rx_valid, 0);
                chk("reset_frame_err", frame_err, 0);
            end
            if (k == 3) rst = 1'b0;
        end
        chk("joined_frame_rx_valid", rv_cnt, 0);
        chk("joined_frame_frame_err", fe_cnt, 0);
        cs = 1'b1;
        repeat (10) @(negedge clk);

        // Single-byte frames from the table
        for (int v = 0; v < 4; v++) begin
            if (vecs[v].ld) load(vecs[v].ld_b);
            if (vecs[v].ld2) begin
`ifndef SPI_SLAVE_DAISY_EN
                chk($sformatf("v%0d_tx_ready_full", v), tx_ready, 0);
`endif
                load(vecs[v].ld2_b);
            end
            rv0 = rv_cnt;
            fe0 = fe_cnt;
            mosi_q[0] = vecs[v].mosi;
            run_frame(1, 1'b0, 8'h00);
            chk($sformatf("v%0d_rx_valid_count", v), rv_cnt - rv0, 1);
            chk($sformatf("v%0d_rx_data", v), rx_data, vecs[v].exp_rx);
`ifdef SPI_SLAVE_DAISY_EN
            chk($sformatf("v%0d_miso", v), miso_q[0], 8'h00);
`else
            chk($sformatf("v%0d_miso", v), miso_q[0], vecs[v].exp_miso);
`endif
            chk($sformatf("v%0d_frame_err", v), fe_cnt - fe0, 0);
        end

        // Two-byte frame, continuous shifting across the byte boundary
        h0 = rx_hist.size();
`ifdef SPI_SLAVE_DAISY_EN
        mosi_q[0] = 8'h11;
        mosi_q[1] = 8'h22;
`else
        load(8'h55);
        mosi_q[0] = 8'h12;
        mosi_q[1] = 8'h34;
`endif
        run_frame(2, 1'b0, 8'h00);
        chk("multi_rx_count", rx_hist.size() - h0, 2);
        if (rx_hist.size() - h0 == 2) begin
            chk("multi_rx0", rx_hist[h0], mosi_q[0]);
            chk("multi_rx1", rx_hist[h0+1], mosi_q[1]);
        end
`ifdef SPI_SLAVE_DAISY_EN
        chk("daisy_miso0", miso_q[0], 8'h00);
        chk("daisy_miso1", miso_q[1], 8'h11);
        last_rx = 8'h22;
`else
        chk("multi_miso0", miso_q[0], 8'h55);
        chk("multi_miso1", miso_q[1], 8'h00);
        last_rx = 8'h34;
`endif

        // cs rises after 4 sclk falls: one frame_err, no rx_valid, sdo low
        load(8'hFF);
        rv0 = rv_cnt;
        fe0 = fe_cnt;
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sdi  = 1'b1;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            repeat (4) @(negedge clk);
        end
        sdo_before = sdo;
        cs = 1'b1;
        repeat (8) @(negedge clk);
`ifdef SPI_SLAVE_DAISY_EN
        chk("abort_sdo_before", sdo_before, 0);
`else
        chk("abort_sdo_before", sdo_before, 1);
`endif
        chk("abort_frame_err", fe_cnt - fe0, 1);
        chk("abort_rx_valid", rv_cnt - rv0, 0);
        chk("abort_sdo", sdo, 0);
        chk("abort_rx_data", rx_data, last_rx);

`ifndef SPI_SLAVE_DAISY_EN
        // Load on the same clk the empty buffer is consumed at frame start
        chk("ldfall_tx_ready_pre", tx_ready, 1);
        rv0 = rv_cnt;
        mosi_q[0] = 8'h0F;
        mosi_q[1] = 8'hF0;
        run_frame(2, 1'b1, 8'h9C);
        chk("ldfall_tx_ready_mid", txr_after_load, 0);
        chk("ldfall_miso0", miso_q[0], 8'h00);
        chk("ldfall_miso1", miso_q[1], 8'h9C);
        chk("ldfall_rx_count", rv_cnt - rv0, 2);
        chk("ldfall_rx_data", rx_data, 8'hF0);
        chk("ldfall_tx_ready_post", tx_ready, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
